// File: rtl/wave_meter_pkg.sv
// Shared definitions for the waveform peak/trough/period meter.
// State encoding, default hysteresis and a widening add for threshold compares.
// No logic of its own; imported by wave_meter.
package wave_meter_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        RISING  = 2'd1,
        FALLING = 2'd2
    } state_e;

    localparam int HYST_DEFAULT = 2;

    // Add hysteresis to a sample in 9 bits so 255 + HYST cannot wrap.
    function automatic logic [8:0] plus_hyst(input logic [7:0] v, input logic [8:0] h);
        return {1'b0, v} + h;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Free-running cycle counter that sticks at all-ones instead of wrapping.
// Latency: count updates on every rising clk; clr reloads 1 on the next edge.
// No backpressure: always counts, sat is a combinational view of the register.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: restart at 1 on clear, otherwise increment until saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = W'(1);
        end else if (!(&count_q)) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register with synchronous reset to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign sat   = &count_q;

endmodule

// File: rtl/wave_meter.sv
// Tracks peaks/troughs of an 8-bit waveform with hysteresis and measures trough-to-trough period.
// Latency: one clk from the triggering sample to meas_valid and updated outputs.
// No backpressure: samples are consumed whenever sample_valid is high.
module wave_meter
    import wave_meter_pkg::*;
#(
    parameter int CTR_W = 32,
    parameter int HYST  = HYST_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [7:0]       sample,
    output logic             meas_valid,
    output logic [7:0]       peak,
    output logic [7:0]       trough,
    output logic [CTR_W-1:0] period,
    output logic             sat,
    output logic             rising
);
    localparam logic [8:0] HYST9 = 9'(HYST);

    state_e           state_q, state_d;
    logic [7:0]       run_max_q, run_max_d;
    logic [7:0]       run_min_q, run_min_d;
    logic [7:0]       peak_r_q, peak_r_d;
    logic             acq_ld_q, acq_ld_d;
    logic             trough_seen_q, trough_seen_d;
    logic             peak_seen_q, peak_seen_d;
    logic             meas_valid_q, meas_valid_d;
    logic [7:0]       peak_q, peak_d;
    logic [7:0]       trough_q, trough_d;
    logic [CTR_W-1:0] period_q, period_d;
    logic             sat_q, sat_d;
    logic             rising_q, rising_d;

    logic             up_hit;
    logic             dn_hit;
    logic             peak_evt;
    logic             trough_evt;
    logic [CTR_W-1:0] ctr_count;
    logic             ctr_sat;

    // Hysteresis thresholds against the running extremes, compared in 9 bits.
    assign up_hit     = {1'b0, sample} >= plus_hyst(run_min_q, HYST9);
    assign dn_hit     = plus_hyst(sample, HYST9) <= {1'b0, run_max_q};
    assign peak_evt   = sample_valid && (state_q == RISING)  && dn_hit;
    assign trough_evt = sample_valid && (state_q == FALLING) && up_hit;

    // Period counter restarts on every trough so it always spans trough to trough.
    sat_counter #(
        .W(CTR_W)
    ) u_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (trough_evt),
        .count(ctr_count),
        .sat  (ctr_sat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACQUIRE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: direction changes only on valid samples that clear the hysteresis band.
    always_comb begin
        state_d = state_q;
        if (sample_valid) begin
            case (state_q)
                ACQUIRE: begin
                    // The first sample only seeds the extremes; it cannot move the state.
                    if (acq_ld_q) begin
                        if (up_hit) begin
                            state_d = RISING;
                        end else if (dn_hit) begin
                            state_d = FALLING;
                        end
                    end
                end
                RISING:  if (dn_hit) state_d = FALLING;
                FALLING: if (up_hit) state_d = RISING;
                default: state_d = ACQUIRE;
            endcase
        end
    end

    // Extremum tracking, event bookkeeping and registered measurement outputs.
    always_comb begin
        run_max_d     = run_max_q;
        run_min_d     = run_min_q;
        peak_r_d      = peak_r_q;
        acq_ld_d      = acq_ld_q;
        trough_seen_d = trough_seen_q;
        peak_seen_d   = peak_seen_q;
        meas_valid_d  = 1'b0;
        peak_d        = peak_q;
        trough_d      = trough_q;
        period_d      = period_q;
        sat_d         = sat_q;

        if (sample_valid && (state_q == ACQUIRE)) begin
            if (!acq_ld_q) begin
                run_max_d = sample;
                run_min_d = sample;
                acq_ld_d  = 1'b1;
            end else if (up_hit) begin
                run_max_d = sample;
            end else if (dn_hit) begin
                run_min_d = sample;
            end
        end

        if (sample_valid && (state_q == RISING) && !dn_hit && (sample > run_max_q)) begin
            run_max_d = sample;
        end

        if (sample_valid && (state_q == FALLING) && !up_hit && (sample < run_min_q)) begin
            run_min_d = sample;
        end

        if (peak_evt) begin
            peak_r_d    = run_max_q;
            run_min_d   = sample;
            peak_seen_d = 1'b1;
        end

        if (trough_evt) begin
            run_max_d     = sample;
            trough_seen_d = 1'b1;
            peak_seen_d   = 1'b0;
            // A full cycle needs a prior trough with a peak between it and this one.
            if (trough_seen_q && peak_seen_q) begin
                meas_valid_d = 1'b1;
                peak_d       = peak_r_q;
                trough_d     = run_min_q;
                period_d     = ctr_count;
                sat_d        = ctr_sat;
            end
        end

        rising_d = (state_d == RISING);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_max_q     <= '0;
            run_min_q     <= '0;
            peak_r_q      <= '0;
            acq_ld_q      <= 1'b0;
            trough_seen_q <= 1'b0;
            peak_seen_q   <= 1'b0;
            meas_valid_q  <= 1'b0;
            peak_q        <= '0;
            trough_q      <= '0;
            period_q      <= '0;
            sat_q         <= 1'b0;
            rising_q      <= 1'b0;
        end else begin
            run_max_q     <= run_max_d;
            run_min_q     <= run_min_d;
            peak_r_q      <= peak_r_d;
            acq_ld_q      <= acq_ld_d;
            trough_seen_q <= trough_seen_d;
            peak_seen_q   <= peak_seen_d;
            meas_valid_q  <= meas_valid_d;
            peak_q        <= peak_d;
            trough_q      <= trough_d;
            period_q      <= period_d;
            sat_q         <= sat_d;
            rising_q      <= rising_d;
        end
    end

    assign meas_valid = meas_valid_q;
    assign peak       = peak_q;
    assign trough     = trough_q;
    assign period     = period_q;
    assign sat        = sat_q;
    assign rising     = rising_q;

endmodule

// File: tb/tb_wave_meter.sv
// Directed bench for wave_meter with a scoreboard of expected measurements.
// Drives triangle, alternate-valid, noise and mid-ramp reset stimulus into 32- and 8-bit counter variants.
// Expected results are derived from the waveform shape and stimulus cycle numbers.
module tb_wave_meter;

    localparam int HYST = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] sample = 8'd0;

    logic        meas_valid, sat, rising;
    logic [7:0]  peak, trough;
    logic [31:0] period;

    logic        meas8, sat8, rising8;
    logic [7:0]  peak8, trough8;
    logic [7:0]  period8;

    wave_meter #(.CTR_W(32), .HYST(HYST)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .meas_valid(meas_valid), .peak(peak), .trough(trough),
        .period(period), .sat(sat), .rising(rising)
    );

    wave_meter #(.CTR_W(8), .HYST(HYST)) dut8 (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .meas_valid(meas8), .peak(peak8), .trough(trough8),
        .period(period8), .sat(sat8), .rising(rising8)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  pk;
        logic [7:0]  tr;
        logic [31:0] per;
        logic        st;
        logic [7:0]  per8;
        logic        st8;
    } exp_t;

    exp_t sb[$];
    exp_t h_out;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int prev_s, troughs, last_trig, exp_rise;
    bit fell, rose;
    int lo_t, hi_t, tv, tdir;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        prev_s   = -1;
        troughs  = 0;
        last_trig = 0;
        fell     = 1'b0;
        rose     = 1'b0;
        h_out    = '0;
        exp_rise = 0;
        sb.delete();
    endtask

    task automatic check_outputs();
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("meas_valid", 32'(meas_valid), 32'd1);
            chk("meas_valid8", 32'(meas8), 32'd1);
            chk("peak", 32'(peak), 32'(e.pk));
            chk("trough", 32'(trough), 32'(e.tr));
            chk("period", period, e.per);
            chk("sat", 32'(sat), 32'(e.st));
            chk("peak8", 32'(peak8), 32'(e.pk));
            chk("trough8", 32'(trough8), 32'(e.tr));
            chk("period8", 32'(period8), 32'(e.per8));
            chk("sat8", 32'(sat8), 32'(e.st8));
            h_out = e;
        end else begin
            chk("meas_valid_idle", 32'(meas_valid), 32'd0);
            chk("meas_valid8_idle", 32'(meas8), 32'd0);
            chk("peak_hold", 32'(peak), 32'(h_out.pk));
            chk("trough_hold", 32'(trough), 32'(h_out.tr));
            chk("period_hold", period, h_out.per);
            chk("sat_hold", 32'(sat), 32'(h_out.st));
            chk("period8_hold", 32'(period8), 32'(h_out.per8));
            chk("sat8_hold", 32'(sat8), 32'(h_out.st8));
        end
        if (exp_rise >= 0) begin
            chk("rising", 32'(rising), 32'(exp_rise));
            chk("rising8", 32'(rising8), 32'(exp_rise));
            exp_rise = -1;
        end
    endtask

    // Bench knowledge of a clean triangle: trough fires HYST above the bottom on the way up,
    // peak fires HYST below the top on the way down.
    task automatic model_sample(input int s);
        exp_t e;
        int   p;
        if (prev_s == lo_t + 1 && s == lo_t) fell = 1'b1;
        if (prev_s == hi_t - 1 && s == hi_t) rose = 1'b1;
        if (fell && prev_s == lo_t + 1 && s == lo_t + HYST) begin
            fell = 1'b0;
            troughs++;
            exp_rise = 1;
            if (troughs >= 2) begin
                p      = cyc - last_trig;
                e.pk   = 8'(hi_t);
                e.tr   = 8'(lo_t);
                e.per  = 32'(p);
                e.st   = 1'b0;
                e.per8 = (p >= 255) ? 8'd255 : 8'(p);
                e.st8  = (p >= 255);
                sb.push_back(e);
            end
            last_trig = cyc;
        end
        if (rose && prev_s == hi_t - 1 && s == hi_t - HYST) begin
            rose = 1'b0;
            exp_rise = 0;
        end
        prev_s = s;
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] s);
        @(posedge clk);
        #1;
        check_outputs();
        rst          = r;
        sample_valid = v;
        sample       = s;
        if (r) begin
            model_reset();
        end else if (v) begin
            model_sample(int'(s));
        end
        cyc++;
    endtask

    task automatic walk(input int count, input bit alt);
        for (int i = 0; i < count; i++) begin
            if (alt) step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
            step(1'b0, 1'b1, 8'(tv));
            if (tdir > 0 && tv == hi_t) tdir = -1;
            else if (tdir < 0 && tv == lo_t) tdir = 1;
            tv += tdir;
        end
    endtask

    initial begin
        model_reset();
        step(1'b1, 1'b0, 8'd0);

        // Full-scale triangle, valid every cycle; 8-bit variant saturates.
        lo_t = 0; hi_t = 255; tv = 0; tdir = 1;
        walk(2050, 1'b0);

        // Continue to sample 200 of a rising ramp, then reset mid-waveform.
        walk(190, 1'b0);
        step(1'b1, 1'b1, 8'd200);
        tv = 201; tdir = 1;
        walk(1400, 1'b0);

        // Same triangle with valid on alternate cycles only.
        step(1'b1, 1'b0, 8'd0);
        lo_t = 0; hi_t = 255; tv = 0; tdir = 1;
        walk(2050, 1'b1);

        // Constant 128 with +/-1 noise: never leaves acquisition.
        step(1'b1, 1'b0, 8'd0);
        lo_t = 0; hi_t = 255;
        step(1'b0, 1'b1, 8'd128);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 8'(127 + $urandom_range(0, 2)));
        end
        exp_rise = 0;
        step(1'b0, 1'b0, 8'd0);

        // Small triangle 10..100.
        step(1'b1, 1'b0, 8'd0);
        lo_t = 10; hi_t = 100; tv = 10; tdir = 1;
        walk(560, 1'b0);

        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_meter.md
WAVE_METER -- requirements
Module: wave_meter

Interface
REQ-001 SHALL have parameter CTR_W, default 32, period counter width in bits (legal range 8..32).
REQ-002 SHALL have parameter HYST, default 2, direction-change hysteresis in LSBs (legal range 1..64).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port sample_valid  input  1  qualifies sample this cycle.
REQ-006 SHALL have port sample  input  8  unsigned waveform sample, e.g. LED fade level.
REQ-007 SHALL have port meas_valid  output  1  one-cycle pulse; new measurement on outputs.
REQ-008 SHALL have port peak  output  8  last confirmed maximum.
REQ-009 SHALL have port trough  output  8  last confirmed minimum.
REQ-010 SHALL have port period  output  CTR_W  clk cycles between the two most recent trough events.
REQ-011 SHALL have port sat  output  1  set when the reported period saturated.
REQ-012 SHALL have port rising  output  1  current tracked direction, 1 = RISING.

Function
REQ-013 SHALL use states ACQUIRE, RISING and FALLING, entering ACQUIRE on reset.
REQ-014 SHALL, on the first valid sample in ACQUIRE, load that sample into both run_max and run_min.
REQ-015 SHALL, in ACQUIRE, go to RISING when sample >= run_min+HYST, or to FALLING when sample+HYST <= run_max.
REQ-016 SHALL, in RISING, update run_max = max(run_max, sample) on each valid sample.
REQ-017 SHALL, in RISING, raise a peak event when sample+HYST <= run_max: peak_r <= run_max, run_min <= sample, state <= FALLING.
REQ-018 SHALL, in FALLING, update run_min = min(run_min, sample) on each valid sample.
REQ-019 SHALL, in FALLING, raise a trough event when sample >= run_min+HYST: trough_r <= run_min, run_max <= sample, state <= RISING.
REQ-020 SHALL evaluate all hysteresis comparisons at 9-bit unsigned width, so 255+HYST does not wrap.
REQ-021 SHALL increment the period counter every clk regardless of sample_valid, saturating at all-ones.
REQ-022 SHALL, on a trough event, capture the counter into period, capture its saturated status into sat, and restart the counter at 1.
REQ-023 SHALL pulse meas_valid on a trough event only if at least one earlier trough event and one intervening peak event have occurred since reset.
REQ-024 SHALL assert meas_valid, and update peak, trough, period and sat, in the clock cycle after the triggering sample is presented (latency 1).
REQ-025 SHALL hold peak, trough, period and sat stable between meas_valid pulses.
REQ-026 SHALL ignore sample entirely while sample_valid = 0, with no state change and no event.
REQ-027 SHALL produce at most one event per valid sample.
REQ-028 SHALL drive rising from state: 1 in RISING, 0 in FALLING and ACQUIRE.

Reset
REQ-029 SHALL, on rst, set state = ACQUIRE, meas_valid = 0, peak = 0, trough = 0, period = 0, sat = 0 and rising = 0.
REQ-030 SHALL, on rst, clear the period counter, run_max, run_min and the first-trough/peak-seen flags.
REQ-031 SHALL let rst asserted mid-waveform discard any partial measurement, with no meas_valid in the reset cycle or the cycle after it.

Structure
REQ-032 SHALL place the state encoding (2-bit ACQUIRE=0, RISING=1, FALLING=2) and the default HYST in shared package wave_meter_pkg.
REQ-033 SHALL implement the saturating period counter as sub-module sat_counter (parameter W; ports clk, rst, clr, count, sat).
REQ-034 SHALL implement the state machine and extremum tracking in wave_meter, with all outputs registered.

Verification
REQ-035 SHALL cover triangle stimulus 0,1..255,254..1,0 repeated, valid every cycle, HYST=2 -> from the second trough event, meas_valid every 510 cycles with peak=255, trough=0, period=510, sat=0.
REQ-036 SHALL cover the same triangle with sample_valid high on alternate cycles only -> period=1020, peak=255, trough=0.
REQ-037 SHALL cover a constant 128 with +/-1 noise, HYST=2 -> no peak or trough event and meas_valid never asserts.
REQ-038 SHALL cover CTR_W=8 with triangle 0..255..0, valid every cycle -> period=255 and sat=1 on each meas_valid.
REQ-039 SHALL cover rst asserted at sample 200 of the rising ramp -> all outputs 0 next cycle, and the first meas_valid only after two further trough events.
REQ-040 SHALL cover triangle 10..100..10, step 1 -> peak=100, trough=10, period=180.
